// File: rtl/elevator_pkg.sv
// Shared door-controller types: FSM states, motor command encodings, floor index width.
package elevator_pkg;
    typedef enum logic [2:0] {
        ST_CLOSED,
        ST_OPENING,
        ST_OPEN,
        ST_CLOSING,
        ST_FAULT
    } door_state_t;

    localparam logic [1:0] MOTOR_STOP  = 2'b00;
    localparam logic [1:0] MOTOR_OPEN  = 2'b01;
    localparam logic [1:0] MOTOR_CLOSE = 2'b10;

    function automatic int floor_w(input int floors);
        return (floors > 1) ? $clog2(floors) : 1;
    endfunction
endpackage

// File: rtl/door_timer.sv
// Loadable saturating down-counter with a zero flag; load wins over decrement.
// Zero flag reflects the registered count, so a load of N reads zero N+1 cycles later.
module door_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/door_ctrl_nfloor.sv
// Car door controller: opens at called floors, times dwell, handles obstruction reopen and stroke watchdog.
// All outputs registered (one cycle after the deciding inputs); no flow control, busy holds the car.
module door_ctrl_nfloor
    import elevator_pkg::*;
#(
    parameter int FLOORS       = 4,
    parameter int DWELL_CYCLES = 1000,
    parameter int MOTION_LIMIT = 200,
    parameter int MAX_REOPEN   = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [FLOORS-1:0]          req_cab,
    input  logic [FLOORS-1:0]          req_up,
    input  logic [FLOORS-1:0]          req_dn,
    input  logic [floor_w(FLOORS)-1:0] floor,
    input  logic                       moving,
    input  logic                       dir_up,
    input  logic                       btn_open,
    input  logic                       btn_close,
    input  logic                       obstruction,
    input  logic                       lim_open,
    input  logic                       lim_closed,
    output logic [1:0]                 motor,
    output logic                       nudge,
    output logic                       busy,
    output logic [FLOORS-1:0]          chime,
    output logic [FLOORS-1:0]          served,
    output logic                       fault
);
    localparam int DW = $clog2(DWELL_CYCLES + 1);
    localparam int MW = $clog2(MOTION_LIMIT + 1);
    localparam int RW = $clog2(MAX_REOPEN + 1);

    door_state_t       r_state, w_next;
    logic [RW-1:0]     r_reopen_cnt, w_reopen_nxt;
    logic              r_hit_prev;
    logic              w_hit, w_hall, w_reopen_req, w_nudge_nxt;
    logic [1:0]        w_motor_nxt;
    logic [FLOORS-1:0] w_onehot, w_chime_nxt, w_served_nxt;
    logic              w_dwell_load, w_dwell_zero, w_stroke_load, w_stroke_zero, w_in_stroke;

    // End landings accept the hall call that points back into the shaft whatever the direction.
    assign w_hall = (req_up[floor] & (dir_up | (floor == '0)))
                  | (req_dn[floor] & (~dir_up | (int'(floor) == FLOORS - 1)));
    assign w_hit        = ~moving & (int'(floor) < FLOORS) & (req_cab[floor] | w_hall);
    assign w_onehot     = FLOORS'(1) << floor;
    assign w_reopen_req = obstruction | btn_open;
    assign w_in_stroke  = (r_state == ST_OPENING) || (r_state == ST_CLOSING);

    door_timer #(.W(DW)) u_dwell (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_dwell_load),
        .i_load_val (DW'(DWELL_CYCLES - 1)),
        .i_dec      (r_state == ST_OPEN),
        .o_zero     (w_dwell_zero)
    );

    door_timer #(.W(MW)) u_stroke (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_stroke_load),
        .i_load_val (MW'(MOTION_LIMIT - 1)),
        .i_dec      (w_in_stroke),
        .o_zero     (w_stroke_zero)
    );

    always_comb begin
        w_next        = r_state;
        w_reopen_nxt  = r_reopen_cnt;
        w_nudge_nxt   = nudge;
        w_chime_nxt   = '0;
        w_served_nxt  = '0;
        w_dwell_load  = 1'b0;
        w_stroke_load = 1'b0;
        w_motor_nxt   = MOTOR_STOP;

        case (r_state)
            ST_CLOSED: begin
                if (w_hit) begin
                    w_next       = ST_OPENING;
                    w_chime_nxt  = w_onehot;
                    w_served_nxt = w_onehot;
                    w_reopen_nxt = '0;
                end else if (btn_open && !moving) begin
                    w_next       = ST_OPENING;
                    w_reopen_nxt = '0;
                end
            end
            ST_OPENING: begin
                if (lim_open) begin
                    w_next = ST_OPEN;
                end else if (w_stroke_zero) begin
                    w_next = ST_FAULT;
                end
            end
            ST_OPEN: begin
                if (w_hit && !r_hit_prev) begin
                    w_served_nxt = w_onehot;
                end
                if (w_reopen_req) begin
                    w_dwell_load = 1'b1;
                end else if (btn_close || w_dwell_zero) begin
                    w_next = ST_CLOSING;
                end
            end
            ST_CLOSING: begin
                if (w_reopen_req && (r_reopen_cnt < RW'(MAX_REOPEN))) begin
                    w_next       = ST_OPENING;
                    w_reopen_nxt = r_reopen_cnt + RW'(1);
                end else begin
                    if (w_reopen_req) begin
                        w_nudge_nxt = 1'b1;
                    end
                    if (lim_closed) begin
                        w_next = ST_CLOSED;
                    end else if (w_stroke_zero) begin
                        w_next = ST_FAULT;
                    end
                end
            end
            ST_FAULT: w_next = ST_FAULT;
            default:  w_next = ST_FAULT;
        endcase

        // Contradictory limits or motion with doors not shut override every normal transition.
        if ((r_state != ST_FAULT) &&
            ((lim_open && lim_closed) || (moving && (r_state != ST_CLOSED)))) begin
            w_next       = ST_FAULT;
            w_chime_nxt  = '0;
            w_served_nxt = '0;
        end

        if (w_next != ST_CLOSING) begin
            w_nudge_nxt = 1'b0;
        end
        w_dwell_load  = w_dwell_load | ((w_next == ST_OPEN) && (r_state != ST_OPEN));
        w_stroke_load = ((w_next == ST_OPENING) || (w_next == ST_CLOSING)) && (w_next != r_state);

        case (w_next)
            ST_OPENING: w_motor_nxt = MOTOR_OPEN;
            ST_CLOSING: w_motor_nxt = MOTOR_CLOSE;
            default:    w_motor_nxt = MOTOR_STOP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_CLOSED;
            r_reopen_cnt <= '0;
            r_hit_prev   <= 1'b0;
            motor        <= MOTOR_STOP;
            nudge        <= 1'b0;
            busy         <= 1'b0;
            fault        <= 1'b0;
            chime        <= '0;
            served       <= '0;
        end else begin
            r_state      <= w_next;
            r_reopen_cnt <= w_reopen_nxt;
            r_hit_prev   <= w_hit;
            motor        <= w_motor_nxt;
            nudge        <= w_nudge_nxt;
            busy         <= (w_next != ST_CLOSED);
            fault        <= (w_next == ST_FAULT);
            chime        <= w_chime_nxt;
            served       <= w_served_nxt;
        end
    end
endmodule
